// File: rtl/vx_kmu_task_dispatch.sv
// Round-robin task dispatcher: one staging register feeds per-core task ports,
// and per-core credit counters cap outstanding work. Define KMU_DISPATCH_PERF_EN to add the stall counter.
module vx_kmu_task_dispatch #(
    parameter int NUM_CORES    = 4,
    parameter int TASK_WIDTH   = 64,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [TASK_WIDTH-1:0]           in_data,
    output logic                            in_ready,
    output logic [NUM_CORES-1:0]            out_valid,
    output logic [NUM_CORES*TASK_WIDTH-1:0] out_data,
    input  logic [NUM_CORES-1:0]            out_ready,
    input  logic [NUM_CORES-1:0]            done,
    output logic                            busy
`ifdef KMU_DISPATCH_PERF_EN
    ,
    output logic [31:0]                     perf_stall_cycles
`endif
);

    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

    logic                  stage_valid_q, stage_valid_d;
    logic [TASK_WIDTH-1:0] stage_data_q, stage_data_d;
    logic [IW-1:0]         stage_core_q, stage_core_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]         outstanding_q [NUM_CORES];
    logic [CW-1:0]         outstanding_d [NUM_CORES];
    logic                  busy_q, busy_d;

    logic [NUM_CORES-1:0]  eligible;
    logic [NUM_CORES-1:0]  inc;
    logic [IW-1:0]         target;
    logic                  found;
    int                    scan_idx;
    logic                  drain;
    logic                  accept;

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            eligible[i] = (outstanding_q[i] < MAX_CNT);
        end
    end

    // First eligible core at or above rr_ptr, wrapping around.
    always_comb begin
        target   = rr_ptr_q;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_CORES;
            if (!found && eligible[scan_idx]) begin
                target = IW'(scan_idx);
                found  = 1'b1;
            end
        end
    end

    assign drain    = stage_valid_q && out_ready[stage_core_q];
    assign in_ready = !reset && (|eligible) && (!stage_valid_q || drain);
    assign accept   = in_valid && in_ready;

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            inc[i] = accept && (target == IW'(i));
        end
    end

    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_data_d  = stage_data_q;
        stage_core_d  = stage_core_q;
        rr_ptr_d      = rr_ptr_q;
        if (drain) begin
            stage_valid_d = 1'b0;
        end
        if (accept) begin
            stage_valid_d = 1'b1;
            stage_data_d  = in_data;
            stage_core_d  = target;
            rr_ptr_d      = (int'(target) == NUM_CORES - 1) ? '0 : target + 1'b1;
        end
    end

    // Credit is reserved at acceptance; a done in the same cycle cancels it out.
    always_comb begin
        busy_d = stage_valid_d;
        for (int i = 0; i < NUM_CORES; i++) begin
            outstanding_d[i] = outstanding_q[i];
            if (inc[i] && !done[i]) begin
                outstanding_d[i] = outstanding_q[i] + 1'b1;
            end else if (!inc[i] && done[i] && (outstanding_q[i] != '0)) begin
                outstanding_d[i] = outstanding_q[i] - 1'b1;
            end
            if (outstanding_d[i] != '0) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            stage_core_q  <= '0;
            rr_ptr_q      <= '0;
            busy_q        <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                outstanding_q[i] <= '0;
            end
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            stage_core_q  <= stage_core_d;
            rr_ptr_q      <= rr_ptr_d;
            busy_q        <= busy_d;
            for (int i = 0; i < NUM_CORES; i++) begin
                outstanding_q[i] <= outstanding_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            out_valid[i]                        = stage_valid_q && (stage_core_q == IW'(i));
            out_data[i*TASK_WIDTH +: TASK_WIDTH] = out_valid[i] ? stage_data_q : '0;
        end
    end

    assign busy = busy_q;

`ifdef KMU_DISPATCH_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (in_valid && !in_ready) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_q;
`endif

`ifndef SYNTHESIS
    // A completion with no credit outstanding means a core misbehaved; it is dropped.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                assert (!(done[i] && (outstanding_q[i] == '0) && !inc[i]))
                else $warning("spurious done on core %0d ignored", i);
            end
        end
    end
`endif

endmodule
